// File: rtl/ysyx_22041412_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms.
// Latency: N+1 cycles from accept (N=64, or 32 for W ops); special cases take 1 cycle.
// Backpressure: requester holds en high until the one-cycle ready pulse; dropping en in CALC aborts.
module ysyx_22041412_div #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            w_en,
    input  logic [XLEN-1:0] rsA,
    input  logic [XLEN-1:0] rsB,
    input  logic [2:0]      func3,
    output logic            ready,
    output logic [XLEN-1:0] result
);

    localparam int HALF = XLEN / 2;
    localparam logic [CNT_W-1:0] N_FULL = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] N_HALF = CNT_W'(HALF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] dvd_q, dvd_d;     // dividend magnitude, MSB-aligned, shifts out left
    logic [XLEN-1:0] dsr_q, dsr_d;     // divisor magnitude
    logic [XLEN-1:0] rem_q, rem_d;     // partial remainder, always < divisor
    logic [XLEN-1:0] quo_q, quo_d;     // quotient bits shifted in at the LSB
    logic [XLEN-1:0] result_q, result_d;
    logic            w_q, w_d;
    logic            rem_sel_q, rem_sel_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;

    // Negate when requested, then for W ops sign-extend from bit HALF-1.
    function automatic logic [XLEN-1:0] fixup(input logic [XLEN-1:0] v,
                                              input logic            neg,
                                              input logic            w);
        logic [XLEN-1:0] t;
        t = neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
        if (w) begin
            t = {{HALF{t[HALF-1]}}, t[HALF-1:0]};
        end
        return t;
    endfunction

    // Operand preparation for the accept cycle: width select, sign capture, magnitudes.
    logic            is_signed;
    logic [XLEN-1:0] a_base, b_base, a_mag, b_mag, min_neg;
    logic            a_sign, b_sign, b_zero, ovf;

    always_comb begin
        is_signed = ~func3[0];
        if (w_en) begin
            a_base = is_signed ? {{HALF{rsA[HALF-1]}}, rsA[HALF-1:0]}
                               : {{HALF{1'b0}}, rsA[HALF-1:0]};
            b_base = is_signed ? {{HALF{rsB[HALF-1]}}, rsB[HALF-1:0]}
                               : {{HALF{1'b0}}, rsB[HALF-1:0]};
            min_neg = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
        end else begin
            a_base  = rsA;
            b_base  = rsB;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_sign = is_signed & a_base[XLEN-1];
        b_sign = is_signed & b_base[XLEN-1];
        a_mag  = a_sign ? (~a_base + {{(XLEN-1){1'b0}}, 1'b1}) : a_base;
        b_mag  = b_sign ? (~b_base + {{(XLEN-1){1'b0}}, 1'b1}) : b_base;
        b_zero = (b_base == '0);
        ovf    = is_signed && (a_base == min_neg) && (b_base == '1);
    end

    // One restoring shift-subtract step on the current iteration state.
    logic [XLEN:0]   rem_sh, diff;
    logic            take;
    logic [XLEN-1:0] rem_n, quo_n;

    always_comb begin
        rem_sh = {rem_q, dvd_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dsr_q};
        take   = ~diff[XLEN];
        rem_n  = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_n  = {quo_q[XLEN-2:0], take};
    end

    // Next-state and datapath control; result is only updated on entry to DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        result_d  = result_q;
        w_d       = w_q;
        rem_sel_d = rem_sel_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    w_d       = w_en;
                    rem_sel_d = func3[1];
                    q_neg_d   = a_sign ^ b_sign;
                    r_neg_d   = a_sign;
                    dsr_d     = b_mag;
                    dvd_d     = w_en ? (a_mag << HALF) : a_mag;
                    rem_d     = '0;
                    quo_d     = '0;
                    if (!func3[2]) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else if (b_zero) begin
                        result_d = func3[1] ? fixup(a_base, 1'b0, w_en) : '1;
                        state_d  = DONE;
                    end else if (ovf) begin
                        result_d = func3[1] ? '0 : fixup(a_base, 1'b0, w_en);
                        state_d  = DONE;
                    end else begin
                        cnt_d   = w_en ? N_HALF : N_FULL;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_n;
                    quo_d = quo_n;
                    dvd_d = dvd_q << 1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        result_d = rem_sel_q ? fixup(rem_n, r_neg_q, w_q)
                                             : fixup(quo_n, q_neg_q, w_q);
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            w_q       <= 1'b0;
            rem_sel_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            result_q  <= result_d;
            w_q       <= w_d;
            rem_sel_q <= rem_sel_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
        end
    end

    assign ready  = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_ysyx_22041412_div.sv
module tb_ysyx_22041412_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        w_en;
    logic [63:0] rsA;
    logic [63:0] rsB;
    logic [2:0]  func3;
    logic        ready;
    logic [63:0] result;

    ysyx_22041412_div #(.XLEN(64), .CNT_W(7)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .w_en   (w_en),
        .rsA    (rsA),
        .rsB    (rsB),
        .func3  (func3),
        .ready  (ready),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] exp_res_q[$];
    int          exp_cyc_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          n_rdy    = 0;

    // Monitor: every ready pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        if (!rst && ready) begin
            n_rdy++;
            if (exp_res_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready cyc=%0d result=%h required=no_pulse", cyc, result);
            end else begin
                logic [63:0] e;
                int          c;
                e = exp_res_q.pop_front();
                c = exp_cyc_q.pop_front();
                checks += 2;
                if (result !== e) begin
                    failures++;
                    $display("FAIL result cyc=%0d actual=%h required=%h", cyc, result, e);
                end
                if (cyc != c) begin
                    failures++;
                    $display("FAIL latency actual_cycle=%0d required_cycle=%0d", cyc, c);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ready_timeout actual=no_pulse required=pulse");
        end
    endtask

    // Issue one request; b2b means en is already high in a DONE cycle and the
    // new operands are accepted in the following IDLE cycle.
    task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_r, input int lat,
                         input bit b2b, input bit hold);
        int k;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        func3 = f3;
        w_en  = w;
        rsA   = a;
        rsB   = b;
        en    = 1'b1;
        k     = b2b ? cyc + 1 : cyc;
        exp_res_q.push_back(exp_r);
        exp_cyc_q.push_back(k + lat);
        wait_ready();
        if (!hold) en = 1'b0;
    endtask

    initial begin
        int r0;
        rst = 1'b1; en = 1'b0; w_en = 1'b0; rsA = '0; rsB = '0; func3 = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;

        issue(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1'b0, 1'b0);
        issue(3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65, 1'b0, 1'b0);
        issue(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0, 1'b0);
        issue(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0, 1'b0);
        issue(3'b101, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, 1'b0);
        issue(3'b111, 1'b0, 64'h1234, 64'd0, 64'h1234, 1, 1'b0, 1'b0);
        issue(3'b000, 1'b0, 64'd55, 64'd5, 64'd0, 1, 1'b0, 1'b0);
        issue(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1, 1'b0, 1'b0);
        issue(3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1'b0, 1'b0);
        issue(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 1, 1'b0, 1'b0);
        issue(3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b0, 1'b0);
        issue(3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
              64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0, 1'b0);

        // Abort: drop en partway through CALC; no pulse, result unchanged.
        @(posedge clk);
        #1;
        func3 = 3'b100; w_en = 1'b0; rsA = 64'd1000; rsB = 64'd3; en = 1'b1;
        r0 = n_rdy;
        repeat (10) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("abort_no_ready", 64'(n_rdy), 64'(r0));
        chk("abort_result_held", result, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(3'b101, 1'b0, 64'd9, 64'd3, 64'd3, 65, 1'b0, 1'b0);

        // Synchronous reset mid-CALC discards the operation.
        @(posedge clk);
        #1;
        func3 = 3'b101; w_en = 1'b0; rsA = 64'd1000; rsB = 64'd3; en = 1'b1;
        r0 = n_rdy;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b0;
        chk("rst_mid_ready", {63'd0, ready}, 64'd0);
        chk("rst_mid_result", result, 64'd0);
        repeat (80) @(posedge clk);
        #1;
        chk("rst_mid_no_ready", 64'(n_rdy), 64'(r0));

        // Back-to-back with en held high across DONE.
        issue(3'b101, 1'b0, 64'd20, 64'd4, 64'd5, 65, 1'b0, 1'b1);
        issue(3'b101, 1'b0, 64'd21, 64'd4, 64'd5, 65, 1'b1, 1'b1);
        issue(3'b111, 1'b0, 64'd21, 64'd4, 64'd1, 65, 1'b1, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_res_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22041412_div.md
Name: ysyx_22041412_div

Overview:
Iterative radix-2 divider for RV64M DIV/DIVU/REM/REMU and their 32-bit W forms. It is the responder on the ALU's multi-cycle execute handshake: the ALU holds en high and stalls while ready is low, then consumes result in the cycle ready is high. It sits beside the multiplier inside the ALU and uses the same en/ready/w_en/func3 interface.

Parameters:
XLEN, 64, operand and result width
CNT_W, 7, iteration counter width (must hold XLEN)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  request; held high by the ALU until ready is sampled high; low aborts
w_en  in  1  1 = 32-bit W op on rsA[31:0]/rsB[31:0]
rsA  in  XLEN  dividend
rsB  in  XLEN  divisor
func3  in  3  100 div, 101 divu, 110 rem, 111 remu
ready  out  1  one-cycle pulse; result is valid in that cycle
result  out  XLEN  quotient or remainder; W ops sign-extended from bit 31

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high: state=IDLE, ready=0, result=0, counter=0. Reset mid-operation discards the operation, and no ready pulse follows.
- FSM states: IDLE, CALC, DONE.
- IDLE, en=1: latch rsA, rsB, func3 and w_en (N=32 if w_en, else 64).
  - Signed ops (func3[0]=0) convert the operands to magnitudes and record the quotient and remainder signs.
  - If func3[2]=0: go to DONE with result 0.
  - Else if the divisor is zero: fast path to DONE.
  - Else if signed and dividend=most-negative(N) and divisor=-1: fast path to DONE.
  - Otherwise load counter=N and go to CALC.
- CALC: one restoring shift-subtract step per cycle, producing one quotient bit MSB-first. Decrement the counter; at counter=1, go to DONE.
- CALC, en=0: abort to IDLE. Do not pulse ready; result keeps its previous value.
- DONE: ready=1 for exactly one cycle and result is driven from a registered value. Then go to IDLE.
  - If en is still high in the cycle after DONE, it is a new request and is accepted from IDLE normally.
- Latency: en first high in cycle k (state IDLE) gives ready=1 in cycle k+N+1, i.e. 65 cycles for 64-bit and 33 for W. Fast paths give ready in cycle k+1.
- Operand or func3 changes after the accept edge are ignored until the next IDLE accept.
- Sign fix-up after the iterations:
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero:
  - Quotient = all ones (-1 at width N).
  - Remainder = dividend.
- Signed overflow:
  - Quotient = dividend.
  - Remainder = 0.
- W ops: compute on the low 32 bits; result = {32{r[31]}, r[31:0]}. This applies to divuw/remuw too, per the RV64 spec.
- result holds its last completed value until the next DONE; its reset value is 0.
- ready is never asserted in IDLE or CALC.

Test Plan:
- divu, rsA=100, rsB=7, en held high -> ready exactly 65 cycles after the first en cycle, result=14. Repeat with remu -> result=2.
- rem, rsA=-7 (0xFFFF_FFFF_FFFF_FFF9), rsB=2 -> result=0xFFFF_FFFF_FFFF_FFFF. div on the same operands -> result=0xFFFF_FFFF_FFFF_FFFD.
- divu by zero, rsA=0x1234 -> ready in cycle k+1, result=0xFFFF_FFFF_FFFF_FFFF. remu by zero, rsA=0x1234 -> result=0x1234.
- divw (w_en=1), rsA=0x0000_0000_8000_0000, rsB=0xFFFF_FFFF_FFFF_FFFF -> fast path, result=0xFFFF_FFFF_8000_0000. divuw 0xFFFF_FFFF/1 -> 33-cycle latency, result=0xFFFF_FFFF_FFFF_FFFF.
- Start div 1000/3, drop en in CALC cycle 10 -> no ready pulse, FSM returns to IDLE. Then divu 9/3 -> ready after 65 cycles, result=3. Also assert rst mid-CALC -> ready stays 0 and result=0.
- Back-to-back: en kept high across DONE with new operands (divu 20/4 then divu 21/4) -> two ready pulses 66 cycles apart, results 5 then 5; then remu 21/4 -> 1.
